// File: rtl/video_loss_monitor.sv
// -----------------------------------------------------------------------------
// video_loss_monitor
//   SDI input supervisor. Watches the vblank/hblank pair coming out of the SDI
//   receiver. It declares video loss when hblank stops during active video. It
//   measures the line length and the number of active lines per frame. Lock is
//   declared after RECOVER_FRAMES consecutive matching frames, and a format
//   change while locked is reported with a one-cycle pulse.
//
// Ports
//   clk_sdi        in   SDI pixel clock
//   rst            in   asynchronous reset, active-high
//   vid_in_vblank  in   vertical blanking (high during vblank)
//   vid_in_hblank  in   horizontal blanking (high during hblank)
//   vid_in_loss_n  out  0 = video lost (state LOSS)
//   vid_lock       out  1 = format stable (state LOCKED)
//   fmt_change     out  one-cycle pulse on a mismatching frame while LOCKED
//   line_len       out  clocks between the last two active-region hblank rises
//   frame_lines    out  active lines counted in the last closed frame
//   mon_state      out  0=LOSS 1=ACQUIRE 2=LOCKED
//   loss_cnt       out  LOSS entry count, saturating at 255
//                       (present only when VLM_LOSS_CNT_EN is defined)
//
// Configuration macro: VLM_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module video_loss_monitor #(
    parameter int CNT_W          = 16,
    parameter int LINE_W         = 12,
    parameter int TIMEOUT        = 4095,
    parameter int RECOVER_FRAMES = 2,
    parameter int LEN_TOL        = 2
) (
    input  logic              clk_sdi,
    input  logic              rst,
    input  logic              vid_in_vblank,
    input  logic              vid_in_hblank,
    output logic              vid_in_loss_n,
    output logic              vid_lock,
    output logic              fmt_change,
    output logic [CNT_W-1:0]  line_len,
    output logic [LINE_W-1:0] frame_lines,
`ifdef VLM_LOSS_CNT_EN
    output logic [7:0]        loss_cnt,
`endif
    output logic [1:0]        mon_state
);

    typedef enum logic [1:0] {
        S_LOSS = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]        TO_VAL   = TIMEOUT[CNT_W-1:0];
    localparam logic [CNT_W-1:0]        CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [LINE_W-1:0]       LINE_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
    localparam logic signed [CNT_W:0]   TOL_POS  = LEN_TOL[CNT_W:0];
    localparam logic signed [CNT_W:0]   TOL_NEG  = -TOL_POS;
    localparam logic [3:0]              REC_VAL  = RECOVER_FRAMES[3:0];

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [LINE_W-1:0] sat_inc_line(input logic [LINE_W-1:0] v);
        return (&v) ? v : v + LINE_ONE;
    endfunction

    // ---- input registers and edge detection
    logic vb_d1, vb_d2, hb_d1, hb_d2;

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            vb_d1 <= 1'b0;
            vb_d2 <= 1'b0;
            hb_d1 <= 1'b0;
            hb_d2 <= 1'b0;
        end else begin
            vb_d1 <= vid_in_vblank;
            vb_d2 <= vb_d1;
            hb_d1 <= vid_in_hblank;
            hb_d2 <= hb_d1;
        end
    end

    logic h_rise, v_rise, v_fall;
    assign h_rise = hb_d1 & ~hb_d2;
    assign v_rise = vb_d1 & ~vb_d2;
    assign v_fall = ~vb_d1 & vb_d2;

    // ---- timeout counter and line measurement
    logic [CNT_W-1:0]  to_cnt, pix_cnt, cur_len;
    logic [LINE_W-1:0] cur_lines;
    logic              to_hit;

    assign to_hit = (to_cnt == TO_VAL);

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            pix_cnt   <= '0;
            cur_len   <= '0;
            cur_lines <= '0;
        end else begin
            // Counter holds during vblank so long blanking gaps never count as loss.
            if (hb_d1)
                to_cnt <= '0;
            else if (!vb_d1 && !to_hit)
                to_cnt <= to_cnt + CNT_ONE;

            pix_cnt <= h_rise ? CNT_ONE : sat_inc_cnt(pix_cnt);

            if (h_rise && !vb_d1)
                cur_len <= pix_cnt;

            // A line starting on the same clock as vblank falls is the first
            // line of the new frame, so the clear and the count combine.
            if (v_fall)
                cur_lines <= (h_rise) ? LINE_ONE : '0;
            else if (h_rise && !vb_d1)
                cur_lines <= sat_inc_line(cur_lines);
        end
    end

    // ---- frame close and reference comparison
    logic [CNT_W-1:0]        ref_len;
    logic [LINE_W-1:0]       ref_lines;
    logic                    ref_valid, refv_nxt, ref_load;
    logic signed [CNT_W:0]   len_diff;
    logic                    match;

    assign len_diff = $signed({1'b0, cur_len}) - $signed({1'b0, ref_len});
    assign match    = ref_valid && (len_diff <= TOL_POS) && (len_diff >= TOL_NEG) &&
                      (cur_lines == ref_lines);

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            line_len    <= '0;
            frame_lines <= '0;
            ref_len     <= '0;
            ref_lines   <= '0;
            ref_valid   <= 1'b0;
        end else begin
            if (v_rise) begin
                line_len    <= cur_len;
                frame_lines <= cur_lines;
            end
            if (ref_load) begin
                ref_len   <= cur_len;
                ref_lines <= cur_lines;
            end
            ref_valid <= refv_nxt;
        end
    end

    // ---- supervisor FSM
    state_t     state, state_nxt;
    logic [3:0] good_cnt, good_nxt, good_inc;
    logic       fmt_nxt;

    assign good_inc = good_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        refv_nxt  = ref_valid;
        ref_load  = 1'b0;
        fmt_nxt   = 1'b0;
        if (to_hit) begin
            state_nxt = S_LOSS;
        end else begin
            case (state)
                S_LOSS: begin
                    if (v_rise) begin
                        state_nxt = S_ACQ;
                        good_nxt  = 4'd0;
                        refv_nxt  = 1'b0;
                    end
                end
                S_ACQ: begin
                    if (v_rise) begin
                        ref_load = 1'b1;
                        refv_nxt = 1'b1;
                        if (match) begin
                            good_nxt = good_inc;
                            if (good_inc == REC_VAL)
                                state_nxt = S_LOCK;
                        end else begin
                            good_nxt = 4'd0;
                        end
                    end
                end
                S_LOCK: begin
                    if (v_rise) begin
                        ref_load = 1'b1;
                        refv_nxt = 1'b1;
                        if (!match) begin
                            state_nxt = S_ACQ;
                            good_nxt  = 4'd0;
                            fmt_nxt   = 1'b1;
                        end
                    end
                end
                default: state_nxt = S_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst) begin
            state         <= S_ACQ;
            good_cnt      <= 4'd0;
            fmt_change    <= 1'b0;
            vid_in_loss_n <= 1'b1;
            vid_lock      <= 1'b0;
        end else begin
            state         <= state_nxt;
            good_cnt      <= good_nxt;
            fmt_change    <= fmt_nxt;
            vid_in_loss_n <= (state_nxt != S_LOSS);
            vid_lock      <= (state_nxt == S_LOCK);
        end
    end

    assign mon_state = state;

`ifdef VLM_LOSS_CNT_EN
    // Only genuine entries into LOSS count; staying in LOSS does not.
    always_ff @(posedge clk_sdi or posedge rst) begin
        if (rst)
            loss_cnt <= 8'd0;
        else if (state_nxt == S_LOSS && state != S_LOSS && loss_cnt != 8'hFF)
            loss_cnt <= loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_video_loss_monitor.sv
module tb_video_loss_monitor;

    logic        clk_sdi;
    logic        rst;
    logic        vid_in_vblank;
    logic        vid_in_hblank;
    logic        vid_in_loss_n;
    logic        vid_lock;
    logic        fmt_change;
    logic [15:0] line_len;
    logic [11:0] frame_lines;
    logic [1:0]  mon_state;
`ifdef VLM_LOSS_CNT_EN
    logic [7:0]  loss_cnt;
`endif

    video_loss_monitor #(
        .CNT_W(16), .LINE_W(12), .TIMEOUT(100), .RECOVER_FRAMES(2), .LEN_TOL(2)
    ) dut (
        .clk_sdi       (clk_sdi),
        .rst           (rst),
        .vid_in_vblank (vid_in_vblank),
        .vid_in_hblank (vid_in_hblank),
        .vid_in_loss_n (vid_in_loss_n),
        .vid_lock      (vid_lock),
        .fmt_change    (fmt_change),
        .line_len      (line_len),
        .frame_lines   (frame_lines),
`ifdef VLM_LOSS_CNT_EN
        .loss_cnt      (loss_cnt),
`endif
        .mon_state     (mon_state)
    );

    initial clk_sdi = 1'b0;
    always #5 clk_sdi = ~clk_sdi;

    typedef struct {
        logic [1:0]  st;
        logic        loss_n;
        logic        lock;
        logic [15:0] len;
        logic [11:0] lines;
        int          fmt;
        int          lcnt;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    int    fmt_seen = 0;

    // Stimulus side: queue the expected output snapshot for this cycle.
    task automatic exp_push(input string nm, input logic [1:0] st, input logic ln,
                            input logic lk, input int len, input int lines,
                            input int fmt, input int lcnt);
        exp_t e;
        e.st = st; e.loss_n = ln; e.lock = lk;
        e.len = len[15:0]; e.lines = lines[11:0];
        e.fmt = fmt; e.lcnt = lcnt;
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // Monitor side: sample mid-cycle, count fmt_change cycles, drain the scoreboard.
    always @(negedge clk_sdi) begin
        exp_t  e;
        string nm;
        logic  bad;
        int    lc;
        #1;
        if (fmt_change === 1'b1) fmt_seen++;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            lc = e.lcnt;
`ifdef VLM_LOSS_CNT_EN
            lc = int'(loss_cnt);
`endif
            n_vec++;
            bad = (mon_state !== e.st) || (vid_in_loss_n !== e.loss_n) ||
                  (vid_lock !== e.lock) || (line_len !== e.len) ||
                  (frame_lines !== e.lines) || (fmt_seen != e.fmt) || (lc != e.lcnt);
            if (bad) begin
                n_miss++;
                $display("FAIL %s: got st=%0d loss_n=%0b lock=%0b len=%0d lines=%0d fmt=%0d lcnt=%0d, want st=%0d loss_n=%0b lock=%0b len=%0d lines=%0d fmt=%0d lcnt=%0d",
                         nm, mon_state, vid_in_loss_n, vid_lock, line_len, frame_lines,
                         fmt_seen, lc, e.st, e.loss_n, e.lock, e.len, e.lines, e.fmt, e.lcnt);
            end
        end
    end

    task automatic line(input logic v, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_sdi);
            vid_in_hblank = (i < 8);
            vid_in_vblank = v;
        end
    endtask

    task automatic frame(input int nl, input int len);
        for (int i = 0; i < nl; i++) line(1'b0, len);
        for (int i = 0; i < 3; i++) line(1'b1, len);
    endtask

    // Start of a line, then hblank stops: returns at the negedge where it went low.
    task automatic stall_start();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sdi);
            vid_in_hblank = 1'b1;
        end
        @(negedge clk_sdi);
        vid_in_hblank = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vid_in_vblank = 1'b0; vid_in_hblank = 1'b0;
        @(negedge clk_sdi);
        exp_push("reset", 2'd1, 1'b1, 1'b0, 0, 0, 0, 0);
        repeat (2) @(negedge clk_sdi);
        rst = 1'b0;

        // 1: three clean frames, lock on the third close
        frame(20, 64); exp_push("t1_f1_ref",  2'd1, 1'b1, 1'b0, 64, 20, 0, 0);
        frame(20, 64); exp_push("t1_f2_acq",  2'd1, 1'b1, 1'b0, 64, 20, 0, 0);
        frame(20, 64); exp_push("t1_f3_lock", 2'd2, 1'b1, 1'b1, 64, 20, 0, 0);

        // 2: hblank stops in active video
        for (int i = 0; i < 3; i++) line(1'b0, 64);
        stall_start();
        repeat (101) @(negedge clk_sdi);
        exp_push("t2_at_timeout", 2'd2, 1'b1, 1'b1, 64, 20, 0, 0);
        @(negedge clk_sdi);
        exp_push("t2_loss",       2'd0, 1'b0, 1'b0, 64, 20, 0, 1);
        repeat (18) @(negedge clk_sdi);
        for (int i = 0; i < 16; i++) line(1'b0, 64);
        for (int i = 0; i < 3; i++) line(1'b1, 64);
        exp_push("t2_acq_on_vrise", 2'd1, 1'b1, 1'b0, 64, 20, 0, 1);

        // 3: relock after three closes; long hblank gap inside vblank is harmless
        frame(20, 64); exp_push("t3_f1", 2'd1, 1'b1, 1'b0, 64, 20, 0, 1);
        frame(20, 64); exp_push("t3_f2", 2'd1, 1'b1, 1'b0, 64, 20, 0, 1);
        frame(20, 64); exp_push("t3_f3_lock", 2'd2, 1'b1, 1'b1, 64, 20, 0, 1);
        for (int i = 0; i < 20; i++) line(1'b0, 64);
        line(1'b1, 64);
        repeat (500) @(negedge clk_sdi);
        line(1'b1, 64); line(1'b1, 64);
        exp_push("t3_vblank_gap", 2'd2, 1'b1, 1'b1, 64, 20, 0, 1);

        // 4: length within tolerance keeps lock; line count change drops it
        frame(20, 66); exp_push("t4_len66",   2'd2, 1'b1, 1'b1, 66, 20, 0, 1);
        frame(21, 64); exp_push("t4_fmtchg",  2'd1, 1'b1, 1'b0, 64, 21, 1, 1);
        frame(21, 64); exp_push("t4_reacq",   2'd1, 1'b1, 1'b0, 64, 21, 1, 1);
        frame(21, 64); exp_push("t4_relock",  2'd2, 1'b1, 1'b1, 64, 21, 1, 1);

        // 5: timeout coincides with vblank rise
        for (int i = 0; i < 4; i++) line(1'b0, 64);
        stall_start();
        repeat (100) @(negedge clk_sdi);
        vid_in_vblank = 1'b1;
        @(negedge clk_sdi);
        exp_push("t5_pre",   2'd2, 1'b1, 1'b1, 64, 21, 1, 1);
        @(negedge clk_sdi);
        exp_push("t5_loss",  2'd0, 1'b0, 1'b0, 64, 5, 1, 2);
        @(negedge clk_sdi);
        exp_push("t5_nofmt", 2'd0, 1'b0, 1'b0, 64, 5, 1, 2);
        line(1'b1, 64); line(1'b1, 64);
        for (int i = 0; i < 5; i++) line(1'b0, 64);

        // reset mid-frame
        @(negedge clk_sdi);
        rst = 1'b1;
        exp_push("t5_rst_mid", 2'd1, 1'b1, 1'b0, 0, 0, 1, 0);
        repeat (3) @(negedge clk_sdi);
        rst = 1'b0; vid_in_hblank = 1'b0; vid_in_vblank = 1'b0;
        frame(20, 64); exp_push("post_f1", 2'd1, 1'b1, 1'b0, 64, 20, 1, 0);
        frame(20, 64); exp_push("post_f2", 2'd1, 1'b1, 1'b0, 64, 20, 1, 0);
        frame(20, 64); exp_push("post_f3", 2'd2, 1'b1, 1'b1, 64, 20, 1, 0);

        @(negedge clk_sdi);
        #3;
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
